// File: rtl/clock_field_editor_pkg.sv
// Shared clock package: edit FSM state encoding, one-hot field select constants,
// field min/max limits, days-in-month constants and the default parameter values
// used by the setup-mode field editor and the date counters.
package clock_field_editor_pkg;

  localparam int VAL_W_DEFAULT      = 7;
  localparam int HOLD_TICKS_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_EDIT    = 2'd2,
    ST_COMMIT  = 2'd3
  } edit_state_t;

  // One-hot field selects, ordered {hour_year, min_month, sec_day}
  localparam logic [2:0] FIELD_SEC_DAY   = 3'b001;
  localparam logic [2:0] FIELD_MIN_MONTH = 3'b010;
  localparam logic [2:0] FIELD_HOUR_YEAR = 3'b100;

  // Field limits (lower limit is 0 unless listed)
  localparam int SEC_MIN_MAX = 59;
  localparam int HOUR_MAX    = 23;
  localparam int DAY_MIN     = 1;
  localparam int MONTH_MIN   = 1;
  localparam int MONTH_MAX   = 12;
  localparam int YEAR_MAX    = 99;

  // Month lengths
  localparam int DIM_LONG     = 31;
  localparam int DIM_SHORT    = 30;
  localparam int DIM_FEB_LEAP = 29;
  localparam int DIM_FEB      = 28;

  function automatic logic is_one_hot3(input logic [2:0] s);
    return (s == FIELD_SEC_DAY) || (s == FIELD_MIN_MONTH) || (s == FIELD_HOUR_YEAR);
  endfunction

endpackage

// File: rtl/clock_days_in_month.sv
// Days-in-month lookup shared by the field editor and the day counter.
// The year is two-digit within 2000-2099, so every year divisible by 4 is leap.
// Ports:
//   month  in  4  month 1..12 (other codes give 31)
//   year   in  7  year 0..99
//   dim    out 5  number of days in that month
module clock_days_in_month
  import clock_field_editor_pkg::*;
(
  input  logic [3:0] month,
  input  logic [6:0] year,
  output logic [4:0] dim
);

  logic leap;

  assign leap = (year % 7'd4) == 7'd0;

  // Month length table; February depends on the leap flag
  always_comb begin
    dim = 5'(DIM_LONG);
    case (month)
      4'd2:                    dim = leap ? 5'(DIM_FEB_LEAP) : 5'(DIM_FEB);
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'(DIM_SHORT);
      default:                 dim = 5'(DIM_LONG);
    endcase
  end

endmodule

// File: rtl/clock_field_editor.sv
// Setup-mode field editor. Captures the time/date field selected by the setup
// FSM, steps it up/down from the buttons (with hold auto-repeat), and writes the
// edited value back to the counters through a valid/ready load handshake.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   edit_en                         setup mode active
//   sel_sec_day/min_month/hour_year one-hot field select from the setup FSM
//   page_date                       0 = time page, 1 = date page
//   btn_up, btn_down                debounced button levels
//   repeat_tick                     1-cycle auto-repeat rate pulse
//   cur_a, cur_b, cur_c             live sec|day, min|month, hour|year values
//   cur_month, cur_year             live month/year for the day limit
//   edit_value                      value being edited
//   pause_count                     freezes time counters while not idle
//   load_valid/field/page/value     write-back request and payload
//   load_ready                      counter accepts the load this cycle
module clock_field_editor
  import clock_field_editor_pkg::*;
#(
  parameter int VAL_W      = VAL_W_DEFAULT,
  parameter int HOLD_TICKS = HOLD_TICKS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             edit_en,
  input  logic             sel_sec_day,
  input  logic             sel_min_month,
  input  logic             sel_hour_year,
  input  logic             page_date,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             repeat_tick,
  input  logic [VAL_W-1:0] cur_a,
  input  logic [VAL_W-1:0] cur_b,
  input  logic [VAL_W-1:0] cur_c,
  input  logic [3:0]       cur_month,
  input  logic [6:0]       cur_year,
  output logic [VAL_W-1:0] edit_value,
  output logic             pause_count,
  output logic             load_valid,
  output logic [2:0]       load_field,
  output logic             load_page,
  output logic [VAL_W-1:0] load_value,
  input  logic             load_ready
);

  localparam int             HCW       = $clog2(HOLD_TICKS + 1);
  localparam logic [HCW-1:0] HOLD_FULL = HCW'(HOLD_TICKS);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_TICKS - 1);
  localparam logic [VAL_W-1:0] ONE     = VAL_W'(1);

  edit_state_t      state;
  logic             dirty;
  logic [2:0]       field_q;
  logic             page_q;
  logic [HCW-1:0]   hold_cnt;
  logic [HCW-1:0]   hold_next;
  logic             btn_up_q;
  logic             btn_down_q;

  logic [2:0]       sel_vec;
  logic             sel_valid;
  logic             field_change;
  logic [VAL_W-1:0] sel_cur;
  logic [VAL_W-1:0] lo;
  logic [VAL_W-1:0] hi;
  logic [VAL_W-1:0] up_value;
  logic [VAL_W-1:0] down_value;
  logic [VAL_W-1:0] step_value;
  logic [4:0]       dim;

  logic             one_btn;
  logic             prev_same;
  logic             btn_edge;
  logic             btn_held;
  logic             repeat_step;
  logic             do_step;

  clock_days_in_month u_dim (
    .month (cur_month),
    .year  (cur_year),
    .dim   (dim)
  );

  assign sel_vec   = {sel_hour_year, sel_min_month, sel_sec_day};
  assign sel_valid = is_one_hot3(sel_vec);

  // Anything other than the latched single field on the latched page ends the edit
  assign field_change = !edit_en || !sel_valid || (sel_vec != field_q) || (page_date != page_q);

  // Live value of the field being selected, taken at capture time
  always_comb begin
    sel_cur = '0;
    case (sel_vec)
      FIELD_SEC_DAY:   sel_cur = cur_a;
      FIELD_MIN_MONTH: sel_cur = cur_b;
      FIELD_HOUR_YEAR: sel_cur = cur_c;
      default:         sel_cur = '0;
    endcase
  end

  // Wrap limits of the latched field; day limit follows the live month/year
  always_comb begin
    lo = '0;
    hi = '0;
    case (field_q)
      FIELD_SEC_DAY: begin
        lo = page_q ? VAL_W'(DAY_MIN) : '0;
        hi = page_q ? VAL_W'(dim) : VAL_W'(SEC_MIN_MAX);
      end
      FIELD_MIN_MONTH: begin
        lo = page_q ? VAL_W'(MONTH_MIN) : '0;
        hi = page_q ? VAL_W'(MONTH_MAX) : VAL_W'(SEC_MIN_MAX);
      end
      FIELD_HOUR_YEAR: begin
        lo = '0;
        hi = page_q ? VAL_W'(YEAR_MAX) : VAL_W'(HOUR_MAX);
      end
      default: begin
        lo = '0;
        hi = '0;
      end
    endcase
  end

  // A day captured above a shortened month limit wraps to the low end going up
  // and snaps to the limit going down
  assign up_value   = (edit_value >= hi) ? lo : edit_value + ONE;
  assign down_value = ((edit_value <= lo) || (edit_value > hi)) ? hi : edit_value - ONE;
  assign step_value = btn_up ? up_value : down_value;

  // Exactly one button may be active; "held" means the same button was also
  // high in the previous cycle, so the press edge itself never counts as a tick
  assign one_btn     = btn_up ^ btn_down;
  assign prev_same   = btn_up ? btn_up_q : btn_down_q;
  assign btn_edge    = one_btn && !prev_same;
  assign btn_held    = one_btn && prev_same;
  assign repeat_step = btn_held && repeat_tick && (hold_cnt >= HOLD_LAST);
  assign do_step     = btn_edge || repeat_step;

  // Hold counter saturates at HOLD_TICKS; from then on every tick steps
  always_comb begin
    hold_next = hold_cnt;
    if (!btn_held) begin
      hold_next = '0;
    end else if (repeat_tick) begin
      hold_next = (hold_cnt >= HOLD_LAST) ? HOLD_FULL : hold_cnt + HCW'(1);
    end
  end

  // Edit sequencer with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      edit_value  <= '0;
      pause_count <= 1'b0;
      load_valid  <= 1'b0;
      load_field  <= 3'b000;
      load_page   <= 1'b0;
      load_value  <= '0;
      dirty       <= 1'b0;
      field_q     <= 3'b000;
      page_q      <= 1'b0;
      hold_cnt    <= '0;
      btn_up_q    <= 1'b0;
      btn_down_q  <= 1'b0;
    end else begin
      btn_up_q   <= btn_up;
      btn_down_q <= btn_down;
      case (state)
        ST_IDLE: begin
          hold_cnt <= '0;
          if (edit_en && sel_valid) begin
            state       <= ST_CAPTURE;
            pause_count <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          hold_cnt <= '0;
          dirty    <= 1'b0;
          if (edit_en && sel_valid) begin
            edit_value <= sel_cur;
            field_q    <= sel_vec;
            page_q     <= page_date;
            state      <= ST_EDIT;
          end else begin
            state       <= ST_IDLE;
            pause_count <= 1'b0;
          end
        end
        ST_EDIT: begin
          if (field_change) begin
            hold_cnt <= '0;
            if (dirty) begin
              state      <= ST_COMMIT;
              load_valid <= 1'b1;
              load_field <= field_q;
              load_page  <= page_q;
              load_value <= edit_value;
            end else begin
              state       <= ST_IDLE;
              pause_count <= 1'b0;
            end
          end else begin
            hold_cnt <= hold_next;
            if (do_step) begin
              edit_value <= step_value;
              dirty      <= 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          hold_cnt <= '0;
          if (load_ready) begin
            state       <= ST_IDLE;
            load_valid  <= 1'b0;
            pause_count <= 1'b0;
            dirty       <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          load_valid  <= 1'b0;
          pause_count <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_field_editor.sv
// Self-checking bench for clock_field_editor. Drives directed and randomized edit
// sessions and compares against a reference built from the field range rules.
module tb_clock_field_editor;

  localparam int VAL_W      = 7;
  localparam int HOLD_TICKS = 5;

  logic             clk;
  logic             rst_n;
  logic             edit_en;
  logic [2:0]       sel;
  logic             page_date;
  logic             btn_up;
  logic             btn_down;
  logic             repeat_tick;
  logic [VAL_W-1:0] cur_a;
  logic [VAL_W-1:0] cur_b;
  logic [VAL_W-1:0] cur_c;
  logic [3:0]       cur_month;
  logic [6:0]       cur_year;
  logic [VAL_W-1:0] edit_value;
  logic             pause_count;
  logic             load_valid;
  logic [2:0]       load_field;
  logic             load_page;
  logic [VAL_W-1:0] load_value;
  logic             load_ready;

  int checks   = 0;
  int failures = 0;
  int op_q[$];

  clock_field_editor #(
    .VAL_W      (VAL_W),
    .HOLD_TICKS (HOLD_TICKS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .edit_en       (edit_en),
    .sel_sec_day   (sel[0]),
    .sel_min_month (sel[1]),
    .sel_hour_year (sel[2]),
    .page_date     (page_date),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .repeat_tick   (repeat_tick),
    .cur_a         (cur_a),
    .cur_b         (cur_b),
    .cur_c         (cur_c),
    .cur_month     (cur_month),
    .cur_year      (cur_year),
    .edit_value    (edit_value),
    .pause_count   (pause_count),
    .load_valid    (load_valid),
    .load_field    (load_field),
    .load_page     (load_page),
    .load_value    (load_value),
    .load_ready    (load_ready)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a stuck run
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [2:0] s, input logic pg);
    edit_en   = en;
    sel       = s;
    page_date = pg;
  endtask

  // Reference: days in month for a 2000-2099 year
  function automatic int ref_dim(input int month, input int year);
    if (month == 2) return (year % 4 == 0) ? 29 : 28;
    if (month == 4 || month == 6 || month == 9 || month == 11) return 30;
    return 31;
  endfunction

  // Reference: legal range of a field
  function automatic void ref_limits(input int fidx, input bit pg, input int month, input int year,
                                     output int lo, output int hi);
    case (fidx)
      0:       begin lo = pg ? 1 : 0; hi = pg ? ref_dim(month, year) : 59; end
      1:       begin lo = pg ? 1 : 0; hi = pg ? 12 : 59; end
      default: begin lo = 0;          hi = pg ? 99 : 23; end
    endcase
  endfunction

  // Reference: one wrapping step
  function automatic int ref_step(input int v, input int lo, input int hi, input bit up);
    if (up) return (v + 1 > hi) ? lo : v + 1;
    return (v - 1 < lo || v > hi) ? hi : v - 1;
  endfunction

  task automatic set_live(input int fidx, input bit pg, input int start, input int month, input int year);
    int l, h;
    int vals[3];
    for (int f = 0; f < 3; f++) begin
      ref_limits(f, pg, month, year, l, h);
      vals[f] = $urandom_range(l, h);
    end
    vals[fidx] = start;
    cur_a     = VAL_W'(vals[0]);
    cur_b     = VAL_W'(vals[1]);
    cur_c     = VAL_W'(vals[2]);
    cur_month = 4'(month);
    cur_year  = 7'(year);
  endtask

  // One edit session: select, run the op list, leave the field, finish handshake.
  // Ops: 1 press up, 2 press down, 3 both buttons, 10+N hold up N ticks, 40+N hold down N ticks
  task automatic run_session(input int fidx, input bit pg, input int start, input int month,
                             input int year, input int exit_kind, input int ready_delay,
                             input bit reset_abort);
    int lo, hi, v, n;
    bit dirty, up;
    ref_limits(fidx, pg, month, year, lo, hi);
    set_live(fidx, pg, start, month, year);
    applyStimulus(1'b1, 3'(1 << fidx), pg);
    repeat (3) @(negedge clk);
    checkOutput("capture_value", 32'(edit_value), start);
    checkOutput("pause_in_edit", 32'(pause_count), 1);
    v = start;
    dirty = 0;
    foreach (op_q[i]) begin
      if (op_q[i] == 1 || op_q[i] == 2) begin
        up = (op_q[i] == 1);
        if (up) btn_up = 1'b1; else btn_down = 1'b1;
        @(negedge clk);
        btn_up = 1'b0;
        btn_down = 1'b0;
        @(negedge clk);
        v = ref_step(v, lo, hi, up);
        dirty = 1;
        checkOutput("press_step", 32'(edit_value), v);
      end else if (op_q[i] == 3) begin
        btn_up = 1'b1;
        btn_down = 1'b1;
        repeat (HOLD_TICKS + 1) begin
          @(negedge clk);
          repeat_tick = 1'b1;
          @(negedge clk);
          repeat_tick = 1'b0;
        end
        btn_up = 1'b0;
        btn_down = 1'b0;
        @(negedge clk);
        checkOutput("both_no_step", 32'(edit_value), v);
      end else begin
        up = (op_q[i] < 40);
        n = up ? op_q[i] - 10 : op_q[i] - 40;
        if (up) btn_up = 1'b1; else btn_down = 1'b1;
        @(negedge clk);
        v = ref_step(v, lo, hi, up);
        dirty = 1;
        checkOutput("hold_first", 32'(edit_value), v);
        for (int t = 1; t <= n; t++) begin
          repeat_tick = 1'b1;
          @(negedge clk);
          repeat_tick = 1'b0;
          if (t >= HOLD_TICKS) v = ref_step(v, lo, hi, up);
          checkOutput("hold_tick", 32'(edit_value), v);
          @(negedge clk);
        end
        btn_up = 1'b0;
        btn_down = 1'b0;
        @(negedge clk);
        checkOutput("hold_release", 32'(edit_value), v);
      end
    end

    case (exit_kind)
      0:       applyStimulus(1'b0, 3'(1 << fidx), pg);
      1:       applyStimulus(1'b1, 3'b000, pg);
      2:       applyStimulus(1'b1, 3'(1 << ((fidx + 1) % 3)), pg);
      3:       applyStimulus(1'b1, 3'b111 & ~3'(1 << fidx), pg);
      default: applyStimulus(1'b1, 3'(1 << fidx), !pg);
    endcase
    @(negedge clk);

    if (dirty) begin
      checkOutput("commit_valid", 32'(load_valid), 1);
      checkOutput("commit_field", 32'(load_field), 32'(1 << fidx));
      checkOutput("commit_page", 32'(load_page), 32'(pg));
      checkOutput("commit_value", 32'(load_value), v);
      checkOutput("commit_pause", 32'(pause_count), 1);
      if (reset_abort) begin
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_load_valid", 32'(load_valid), 0);
        checkOutput("rst_load_field", 32'(load_field), 0);
        checkOutput("rst_load_page", 32'(load_page), 0);
        checkOutput("rst_load_value", 32'(load_value), 0);
        checkOutput("rst_edit_value", 32'(edit_value), 0);
        checkOutput("rst_pause", 32'(pause_count), 0);
        @(negedge clk);
        applyStimulus(1'b0, 3'b000, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("after_rst_idle", 32'(load_valid), 0);
      end else begin
        repeat (ready_delay) begin
          @(negedge clk);
          applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
        checkOutput("stable_valid", 32'(load_valid), 1);
        checkOutput("stable_field", 32'(load_field), 32'(1 << fidx));
        checkOutput("stable_page", 32'(load_page), 32'(pg));
        checkOutput("stable_value", 32'(load_value), v);
        applyStimulus(1'b0, 3'b000, 1'b0);
        load_ready = 1'b1;
        @(negedge clk);
        load_ready = 1'b0;
        checkOutput("done_valid", 32'(load_valid), 0);
        checkOutput("done_pause", 32'(pause_count), 0);
      end
    end else begin
      checkOutput("clean_no_load", 32'(load_valid), 0);
      checkOutput("clean_pause", 32'(pause_count), 0);
      applyStimulus(1'b0, 3'b000, 1'b0);
      @(negedge clk);
      checkOutput("clean_still_idle", 32'(load_valid), 0);
    end
  endtask

  // Main sequence: reset, directed boundary sessions, then random sessions
  initial begin
    int fidx, start, month, year, lo, hi, nops;
    bit pg;
    rst_n       = 1'b0;
    edit_en     = 1'b0;
    sel         = 3'b000;
    page_date   = 1'b0;
    btn_up      = 1'b0;
    btn_down    = 1'b0;
    repeat_tick = 1'b0;
    load_ready  = 1'b0;
    cur_a       = '0;
    cur_b       = '0;
    cur_c       = '0;
    cur_month   = 4'd1;
    cur_year    = 7'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_edit_value", 32'(edit_value), 0);
    checkOutput("reset_pause", 32'(pause_count), 0);
    checkOutput("reset_load_valid", 32'(load_valid), 0);
    checkOutput("reset_load_field", 32'(load_field), 0);
    checkOutput("reset_load_page", 32'(load_page), 0);
    checkOutput("reset_load_value", 32'(load_value), 0);
    rst_n = 1'b1;
    @(negedge clk);

    op_q = '{1};       run_session(1, 1'b0, 59, 6, 20, 1, 10, 1'b0);
    op_q = '{2};       run_session(2, 1'b0, 0, 6, 20, 0, 2, 1'b0);
    op_q = '{2};       run_session(0, 1'b0, 0, 6, 20, 2, 1, 1'b0);
    op_q = '{2};       run_session(1, 1'b1, 1, 6, 20, 4, 0, 1'b0);
    op_q = '{1};       run_session(2, 1'b1, 99, 6, 20, 3, 3, 1'b0);
    op_q = '{18};      run_session(1, 1'b0, 10, 6, 20, 0, 1, 1'b0);
    op_q = '{1, 1};    run_session(0, 1'b1, 28, 2, 24, 0, 1, 1'b0);
    op_q = '{1};       run_session(0, 1'b1, 28, 2, 23, 0, 1, 1'b0);
    op_q = '{1};       run_session(0, 1'b1, 30, 4, 23, 0, 1, 1'b0);
    op_q = '{1};       run_session(0, 1'b1, 31, 4, 23, 1, 1, 1'b0);
    op_q = '{2};       run_session(0, 1'b1, 31, 4, 23, 1, 1, 1'b0);
    op_q.delete();     run_session(2, 1'b0, 7, 6, 20, 1, 0, 1'b0);
    op_q = '{3};       run_session(0, 1'b0, 33, 6, 20, 4, 0, 1'b0);
    op_q = '{1};       run_session(0, 1'b0, 5, 6, 20, 0, 3, 1'b1);

    for (int s = 0; s < 30; s++) begin
      fidx  = $urandom_range(0, 2);
      pg    = 1'($urandom_range(0, 1));
      month = $urandom_range(1, 12);
      year  = $urandom_range(0, 99);
      ref_limits(fidx, pg, month, year, lo, hi);
      start = (fidx == 0 && pg) ? $urandom_range(1, 31) : $urandom_range(lo, hi);
      op_q.delete();
      nops = $urandom_range(0, 4);
      for (int k = 0; k < nops; k++) begin
        case ($urandom_range(0, 4))
          0:       op_q.push_back(1);
          1:       op_q.push_back(2);
          2:       op_q.push_back(3);
          3:       op_q.push_back(10 + $urandom_range(1, 8));
          default: op_q.push_back(40 + $urandom_range(1, 8));
        endcase
      end
      run_session(fidx, pg, start, month, year, $urandom_range(0, 4), $urandom_range(0, 6), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
